// File: rtl/regmap_byte_bridge_if.sv
// rtl/regmap_byte_bridge_if.sv - byte receive, regmap and response signals of the byte bridge
interface regmap_byte_bridge_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  i_rx_valid;
  logic [7:0]            i_rx_data;
  logic                  o_rx_ready;
  logic                  o_wren;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [7:0]            o_wrdata;
  logic                  i_rdvalid;
  logic [7:0]            i_rddata;
  logic                  o_tx_valid;
  logic [7:0]            o_tx_data;
  logic                  i_tx_ready;
  logic                  o_timeout;
  logic                  o_cmd_err;
  logic                  o_overrun;

  modport slave (
    input  i_rx_valid, i_rx_data, i_rdvalid, i_rddata, i_tx_ready,
    output o_rx_ready, o_wren, o_addr, o_wrdata, o_tx_valid, o_tx_data,
           o_timeout, o_cmd_err, o_overrun
  );

  modport master (
    output i_rx_valid, i_rx_data, i_rdvalid, i_rddata, i_tx_ready,
    input  o_rx_ready, o_wren, o_addr, o_wrdata, o_tx_valid, o_tx_data,
           o_timeout, o_cmd_err, o_overrun
  );
endinterface

// File: rtl/regmap_byte_bridge.sv
// rtl/regmap_byte_bridge.sv - byte command decoder driving regmap writes and single-byte read responses
module regmap_byte_bridge #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  regmap_byte_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, TX} state_t;

  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                state, next;
  logic                  rx_ready, wren, cmd_err, timeout, overrun, tx_valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            wrdata, tx_data;
  logic [CNT_WIDTH-1:0]  cnt;

  logic accept, bad_cmd, tmo_hit, in_wait;
  logic wren_d, err_d, tmo_d, load_addr, load_wr, load_tx;

  assign accept  = bus.i_rx_valid && rx_ready;
  // Bits between the address field and the R/W flag must be zero.
  assign bad_cmd = (bus.i_rx_data[6:0] >> ADDR_WIDTH) != 7'd0;
  assign in_wait = (state == WR_DATA) || (state == RD_WAIT);
  assign tmo_hit = TMO_EN && (cnt == CNT_LAST);

  always_comb begin
    next      = state;
    wren_d    = 1'b0;
    err_d     = 1'b0;
    tmo_d     = 1'b0;
    load_addr = 1'b0;
    load_wr   = 1'b0;
    load_tx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad_cmd) begin
            err_d = 1'b1;
          end else begin
            load_addr = 1'b1;
            next      = bus.i_rx_data[7] ? WR_DATA : RD_WAIT;
          end
        end
      end
      WR_DATA: begin
        // An arriving data byte beats a timeout in the same cycle.
        if (accept) begin
          load_wr = 1'b1;
          wren_d  = 1'b1;
          next    = IDLE;
        end else if (tmo_hit) begin
          tmo_d = 1'b1;
          next  = IDLE;
        end
      end
      RD_WAIT: begin
        if (bus.i_rdvalid) begin
          load_tx = 1'b1;
          next    = TX;
        end else if (tmo_hit) begin
          tmo_d = 1'b1;
          next  = IDLE;
        end
      end
      TX: begin
        if (bus.i_tx_ready) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rx_ready <= 1'b1;
      wren     <= 1'b0;
      cmd_err  <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
      tx_valid <= 1'b0;
      addr     <= '0;
      wrdata   <= 8'd0;
      tx_data  <= 8'd0;
      cnt      <= '0;
    end else begin
      state    <= next;
      rx_ready <= (next == IDLE) || (next == WR_DATA);
      wren     <= wren_d;
      cmd_err  <= err_d;
      timeout  <= tmo_d;
      tx_valid <= (next == TX);
      if (bus.i_rx_valid && !rx_ready) overrun <= 1'b1;
      if (load_addr) addr    <= bus.i_rx_data[ADDR_WIDTH-1:0];
      if (load_wr)   wrdata  <= bus.i_rx_data;
      if (load_tx)   tx_data <= bus.i_rddata;
      // Count only while parked in a waiting state; any entry or accepted byte restarts.
      if (!TMO_EN || !in_wait || (next != state) || accept) cnt <= '0;
      else                                                 cnt <= cnt + 1'b1;
    end
  end

  assign bus.o_rx_ready = rx_ready;
  assign bus.o_wren     = wren;
  assign bus.o_addr     = addr;
  assign bus.o_wrdata   = wrdata;
  assign bus.o_tx_valid = tx_valid;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_timeout  = timeout;
  assign bus.o_cmd_err  = cmd_err;
  assign bus.o_overrun  = overrun;

endmodule
